dual_port_capture_ram: RTL and testbench

- Parametrised simple-dual-port RAM: one write port and one read port, both on `clock`, with independent addresses.
- Used as the capture buffer behind the ILA trigger and sample logic. The write port takes samples; the read port serves host readout in the same cycle.
- Adds over the previous single-port RAM:
  - registered read with a valid strobe;
  - defined read-during-write behaviour;
  - a hardware clear engine that fills memory with INIT_VALUE after reset or on request.

---
 rtl/ram_pkg.sv | 12 +
 rtl/ram_clear_fsm.sv | 68 ++++++
 rtl/dual_port_capture_ram.sv | 116 +++++++++++
 tb/tb_dual_port_capture_ram.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types for the capture RAM: clear-engine state and read-during-write modes.
package ram_pkg;

  typedef enum logic {
    IDLE,
    CLEAR
  } ram_state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/ram_clear_fsm.sv
// Clear engine: walks every address once, writing INIT_VALUE,
// after reset (optional) or on clear_req_i; drives a write-port override.
module ram_clear_fsm
  import ram_pkg::*;
#(
  parameter int              ADDR_W         = 10,
  parameter int              DATA_W         = 8,
  parameter int              CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE   = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_req_i,
  output logic              busy_o,
  output logic              clr_done_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic [DATA_W-1:0] clr_data_o
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(2**ADDR_W - 1);

  ram_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_o     = 1'b0;
    clr_done_o = 1'b0;
    clr_we_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear_req_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        busy_o   = 1'b1;
        clr_we_o = 1'b1;
        if (cnt_q == LAST) begin
          clr_done_o = 1'b1;
          state_d    = IDLE;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign clr_addr_o = cnt_q[ADDR_W-1:0];
  assign clr_data_o = INIT_VALUE;

endmodule

// File: rtl/dual_port_capture_ram.sv
// Simple-dual-port capture RAM with registered read, RDW control and clear engine.
// Optional stored even parity: define DUAL_PORT_CAPTURE_RAM_PARITY_EN.
module dual_port_capture_ram
  import ram_pkg::*;
#(
  parameter int              DATA_W         = 8,
  parameter int              ADDR_W         = 10,
  parameter int              RDW_MODE       = 0,
  parameter int              CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE   = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_done
`ifdef DUAL_PORT_CAPTURE_RAM_PARITY_EN
  ,
  output logic              rd_parity_err
`endif
);

  localparam int DEPTH = 2**ADDR_W;
`ifdef DUAL_PORT_CAPTURE_RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_data;

  ram_clear_fsm #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET),
    .INIT_VALUE     (INIT_VALUE)
  ) u_clr (
    .clock       (clock),
    .reset       (reset),
    .clear_req_i (clear_req),
    .busy_o      (busy),
    .clr_done_o  (clr_done),
    .clr_we_o    (clr_we),
    .clr_addr_o  (clr_addr),
    .clr_data_o  (clr_data)
  );

  logic [MEM_W-1:0]  mem_q [DEPTH];
  logic              usr_we, usr_re, mem_we, bypass;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MEM_W-1:0]  mem_wword, rd_word;

  assign usr_we    = wr_en & ~busy;
  assign usr_re    = rd_en & ~busy;
  assign mem_we    = clr_we | usr_we;
  assign mem_waddr = clr_we ? clr_addr : wr_addr;
  assign mem_wdata = clr_we ? clr_data : wr_data;

`ifdef DUAL_PORT_CAPTURE_RAM_PARITY_EN
  assign mem_wword = {^mem_wdata, mem_wdata};
`else
  assign mem_wword = mem_wdata;
`endif

  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wword;
  end

  // Write-first bypass only ever sees user writes: the clear engine
  // and user reads are mutually exclusive.
  assign bypass  = (RDW_MODE == RDW_NEW) && usr_we && (wr_addr == rd_addr);
  assign rd_word = bypass ? mem_wword : mem_q[rd_addr];

  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= usr_re;
      if (usr_re) rd_data_q <= rd_word[DATA_W-1:0];
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

`ifdef DUAL_PORT_CAPTURE_RAM_PARITY_EN
  logic rd_perr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_perr_q <= 1'b0;
    end else if (usr_re) begin
      rd_perr_q <= ^rd_word;
    end else begin
      rd_perr_q <= 1'b0;
    end
  end

  assign rd_parity_err = rd_perr_q;
`endif

endmodule

// File: tb/tb_dual_port_capture_ram.sv
// Bench: two DUTs (old-data and new-data RDW) share stimulus, checked against an array model.
module tb_dual_port_capture_ram;

  localparam int          DW    = 8;
  localparam int          AW    = 10;
  localparam int          DEPTH = 1024;
  localparam logic [7:0]  INIT  = 8'hA5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          clear_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] wr_data = '0;

  logic [DW-1:0] rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1;
  logic          busy0, busy1, clr_done0, clr_done1;
`ifdef DUAL_PORT_CAPTURE_RAM_PARITY_EN
  logic          perr0, perr1;
`endif

  always #5 clock = ~clock;

  dual_port_capture_ram #(
    .DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0),
    .CLEAR_ON_RESET(1), .INIT_VALUE(INIT)
  ) dut0 (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_valid(rd_valid0),
    .clear_req(clear_req), .busy(busy0), .clr_done(clr_done0)
`ifdef DUAL_PORT_CAPTURE_RAM_PARITY_EN
    , .rd_parity_err(perr0)
`endif
  );

  dual_port_capture_ram #(
    .DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1),
    .CLEAR_ON_RESET(1), .INIT_VALUE(INIT)
  ) dut1 (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1),
    .clear_req(clear_req), .busy(busy1), .clr_done(clr_done1)
`ifdef DUAL_PORT_CAPTURE_RAM_PARITY_EN
    , .rd_parity_err(perr1)
`endif
  );

  logic [DW-1:0] m_mem [DEPTH];
  int            clr_left;
  logic [DW-1:0] m_rd0, m_rd1;
  logic          m_val;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("rd_data0", 64'(rd_data0), 64'(m_rd0));
    chk("rd_data1", 64'(rd_data1), 64'(m_rd1));
    chk("rd_valid0", 64'(rd_valid0), 64'(m_val));
    chk("rd_valid1", 64'(rd_valid1), 64'(m_val));
    chk("busy0", 64'(busy0), 64'(clr_left > 0));
    chk("busy1", 64'(busy1), 64'(clr_left > 0));
    chk("clr_done0", 64'(clr_done0), 64'(clr_left == 1));
    chk("clr_done1", 64'(clr_done1), 64'(clr_left == 1));
  endtask

  // One clock cycle: drive at negedge, advance model at posedge, check after.
  task automatic step(input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic re,
                      input logic [AW-1:0] ra, input logic cr);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra; clear_req = cr;
    @(posedge clock);
    if (clr_left > 0) begin
      m_mem[DEPTH - clr_left] = INIT;
      clr_left--;
      m_val = 1'b0;
    end else begin
      if (re) begin
        m_rd0 = m_mem[ra];
        m_rd1 = (we && wa == ra) ? wd : m_mem[ra];
      end
      m_val = re;
      if (we) m_mem[wa] = wd;
      if (cr) clr_left = DEPTH;
    end
    #1 check_all();
    @(negedge clock);
    wr_en = 1'b0; rd_en = 1'b0; clear_req = 1'b0;
  endtask

  task automatic rand_step(input logic allow_clear);
    logic [AW-1:0] wa, ra;
    wa = ($urandom % 4 == 0) ? AW'($urandom % 16) : AW'($urandom);
    ra = ($urandom % 3 == 0) ? wa : AW'($urandom);
    step(1'($urandom), wa, DW'($urandom), 1'($urandom), ra,
         allow_clear && ($urandom % 700 == 0));
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_rd_data"}, 64'(rd_data0), 64'h0);
    chk({tag, "_rd_data1"}, 64'(rd_data1), 64'h0);
    chk({tag, "_rd_valid"}, 64'(rd_valid0), 64'h0);
    chk({tag, "_clr_done"}, 64'(clr_done0), 64'h0);
    chk({tag, "_busy"}, 64'(busy0), 64'h1);
    m_rd0 = '0; m_rd1 = '0; m_val = 1'b0;
    clr_left = DEPTH;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Runs a clear to completion with random user traffic; checks its length.
  task automatic run_clear(input string tag, input int req_at);
    int n = 0;
    int done_at = -1;
    while (busy0 && n < 2000) begin
      if (clr_done0) done_at = n + 1;
      rand_step(1'b0);
      if (n == req_at) step(1'b0, '0, '0, 1'b1, '0, 1'b1);
      n = n + ((n == req_at) ? 2 : 1);
    end
    chk({tag, "_busy_len"}, 64'(n), 64'(DEPTH));
    chk({tag, "_done_at"}, 64'(done_at), 64'(DEPTH));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = INIT;
    clr_left = DEPTH;
    m_rd0 = '0; m_rd1 = '0; m_val = 1'b0;
    @(negedge clock);
    apply_reset("rst");
    run_clear("clr0", -1);

    step(1'b0, '0, '0, 1'b1, 10'd0, 1'b0);
    chk("init_addr0", 64'(rd_data0), 64'hA5);
    step(1'b0, '0, '0, 1'b1, 10'd511, 1'b0);
    chk("init_addr511", 64'(rd_data0), 64'hA5);
    step(1'b0, '0, '0, 1'b1, 10'd1023, 1'b0);
    chk("init_addr1023", 64'(rd_data1), 64'hA5);

    step(1'b1, 10'd10, 8'h3C, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 10'd10, 1'b0);
    chk("wr_rd_data", 64'(rd_data0), 64'h3C);
    chk("wr_rd_valid", 64'(rd_valid0), 64'h1);
    step(1'b0, '0, '0, 1'b0, 10'd11, 1'b0);
    chk("hold_data", 64'(rd_data0), 64'h3C);
    chk("hold_valid", 64'(rd_valid0), 64'h0);

    step(1'b1, 10'd20, 8'h11, 1'b0, '0, 1'b0);
    step(1'b1, 10'd20, 8'h77, 1'b1, 10'd20, 1'b0);
    chk("rdw_old", 64'(rd_data0), 64'h11);
    chk("rdw_new", 64'(rd_data1), 64'h77);

    for (int i = 0; i < 3000; i++) rand_step(1'b1);
    for (int i = 0; i < 1100 && clr_left > 0; i++) rand_step(1'b0);

    step(1'b1, 10'd3, 8'h5A, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 10'd3, 1'b1);
    for (int i = 0; i < 300; i++) rand_step(1'b0);
    #2;
    apply_reset("midclr");
    run_clear("clr1", 500);
    step(1'b0, '0, '0, 1'b1, 10'd3, 1'b0);
    chk("after_abort", 64'(rd_data0), 64'hA5);

`ifdef DUAL_PORT_CAPTURE_RAM_PARITY_EN
    dut0.mem_q[5][DW] = ~dut0.mem_q[5][DW];
    step(1'b0, '0, '0, 1'b1, 10'd5, 1'b0);
    chk("perr_bad", 64'(perr0), 64'h1);
    chk("perr_bad_valid", 64'(rd_valid0), 64'h1);
    chk("perr_other_dut", 64'(perr1), 64'h0);
    step(1'b0, '0, '0, 1'b1, 10'd6, 1'b0);
    chk("perr_clean", 64'(perr0), 64'h0);
`endif

    for (int i = 0; i < 200; i++) rand_step(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
